// File: rtl/ras_sequencer.sv
// ras_sequencer: sequences push/pop of an 8-entry return-address stack for
// CALL/RET requests from the control unit and loads the PC accordingly.
// A private depth mirror rejects overflow/underflow before the stack is touched.
// Optional build macro: RAS_TOP_CACHE_EN keeps a cached top-of-stack copy so a
// RET that directly follows a push completes with a one-cycle latency.
module ras_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned RET_OFFSET = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            call_req,
    input  logic            ret_req,
    output logic            req_ready,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] call_target,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            stack_clr,
    output logic            stack_push,
    output logic            stack_pop,
    output logic [PC_W-1:0] stack_din,
    input  logic [PC_W-1:0] stack_dout,
    input  logic            stack_ovf,
    output logic [3:0]      depth,
    output logic            fault,
    output logic [1:0]      fault_code,
    input  logic            fault_clr
);

    localparam int unsigned DEPTH_W = 4;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
    localparam logic [PC_W-1:0]    RA_INC    = PC_W'(RET_OFFSET);

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_PUSH  = 3'd2,
        S_POP   = 3'd3,
        S_WAIT  = 3'd4,
        S_LOAD  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [1:0]           fault_code_q, fault_code_d;
    logic                 fault_q, fault_d;
    logic [PC_W-1:0]      pc_next_q, pc_next_d;
    logic [PC_W-1:0]      stack_din_q, stack_din_d;
    logic                 stack_clr_q, stack_clr_d;
    logic                 stack_push_q, stack_push_d;
    logic                 stack_pop_q, stack_pop_d;
    logic                 pc_load_q, pc_load_d;
    logic                 req_ready_q, req_ready_d;
    logic                 fast_ret_c;

    logic                 top_valid_q;
    logic [PC_W-1:0]      top_q;

    // Next-state, depth mirror and registered-output decode.
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        fault_code_d = fault_code_q;
        pc_next_d    = pc_next_q;
        stack_din_d  = stack_din_q;
        stack_clr_d  = 1'b0;
        fast_ret_c   = 1'b0;

        unique case (state_q)
            S_INIT: begin
                // Hold INIT until the clear strobe has been issued once.
                if (stack_clr_q) begin
                    state_d = S_IDLE;
                end else begin
                    stack_clr_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (call_req && ret_req) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_ILL;
                end else if (call_req) begin
                    if (depth_q == DEPTH_MAX) begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_OVF;
                    end else begin
                        state_d     = S_PUSH;
                        stack_din_d = pc + RA_INC;
                        pc_next_d   = call_target;
                    end
                end else if (ret_req) begin
                    if (depth_q == '0) begin
                        state_d      = S_FAULT;
                        fault_code_d = FC_UNF;
                    end else begin
                        state_d = S_POP;
                        if (top_valid_q) begin
                            pc_next_d  = top_q;
                            fast_ret_c = 1'b1;
                        end
                    end
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
                depth_d = depth_q + DEPTH_W'(1);
            end
            S_POP: begin
                // pc_load already high here means the cached copy served the RET.
                if (pc_load_q) begin
                    state_d = S_IDLE;
                    depth_d = depth_q - DEPTH_W'(1);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                pc_next_d = stack_dout;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_IDLE;
                depth_d = depth_q - DEPTH_W'(1);
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d      = S_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // A stack overflow flag means the depth mirror disagrees with the stack.
        if (stack_ovf && (state_q != S_INIT) && (state_q != S_FAULT)) begin
            state_d      = S_FAULT;
            fault_code_d = FC_ILL;
            depth_d      = depth_q;
            pc_next_d    = pc_next_q;
            stack_din_d  = stack_din_q;
            stack_clr_d  = 1'b0;
            fast_ret_c   = 1'b0;
        end

        req_ready_d  = (state_d == S_IDLE);
        stack_push_d = (state_d == S_PUSH);
        stack_pop_d  = (state_d == S_POP);
        pc_load_d    = (state_d == S_PUSH) || (state_d == S_LOAD) || fast_ret_c;
        fault_d      = (state_d == S_FAULT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            depth_q      <= '0;
            fault_code_q <= FC_NONE;
            fault_q      <= 1'b0;
            pc_next_q    <= '0;
            stack_din_q  <= '0;
            stack_clr_q  <= 1'b0;
            stack_push_q <= 1'b0;
            stack_pop_q  <= 1'b0;
            pc_load_q    <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            fault_code_q <= fault_code_d;
            fault_q      <= fault_d;
            pc_next_q    <= pc_next_d;
            stack_din_q  <= stack_din_d;
            stack_clr_q  <= stack_clr_d;
            stack_push_q <= stack_push_d;
            stack_pop_q  <= stack_pop_d;
            pc_load_q    <= pc_load_d;
            req_ready_q  <= req_ready_d;
        end
    end

`ifdef RAS_TOP_CACHE_EN
    // Cached copy of the most recently pushed return address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_valid_q <= 1'b0;
            top_q       <= '0;
        end else if (state_d == S_FAULT) begin
            top_valid_q <= 1'b0;
        end else if (stack_pop_q) begin
            top_valid_q <= 1'b0;
        end else if (stack_push_q) begin
            top_valid_q <= 1'b1;
            top_q       <= stack_din_q;
        end
    end
`else
    assign top_valid_q = 1'b0;
    assign top_q       = '0;
`endif

    assign req_ready  = req_ready_q;
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign stack_clr  = stack_clr_q;
    assign stack_push = stack_push_q;
    assign stack_pop  = stack_pop_q;
    assign stack_din  = stack_din_q;
    assign depth      = depth_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_ras_sequencer.sv
// tb_ras_sequencer: directed plus randomized CALL/RET traffic against a
// queue-based return-address model, with a simple stack attached to the DUT.
module tb_ras_sequencer;

`ifdef RAS_TOP_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        call_req;
    logic        ret_req;
    logic        req_ready;
    logic [31:0] pc;
    logic [31:0] call_target;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        stack_clr;
    logic        stack_push;
    logic        stack_pop;
    logic [31:0] stack_din;
    logic [31:0] stack_dout;
    logic        stack_ovf;
    logic [3:0]  depth;
    logic        fault;
    logic [1:0]  fault_code;
    logic        fault_clr;

    int tests = 0;
    int fails = 0;

    // Reference model: return addresses still owed to the program.
    logic [31:0] ras_q[$];
    bit          cache_valid;

    ras_sequencer #(.DEPTH(8), .PC_W(32), .RET_OFFSET(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .req_ready  (req_ready),
        .pc         (pc),
        .call_target(call_target),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .stack_clr  (stack_clr),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .stack_din  (stack_din),
        .stack_dout (stack_dout),
        .stack_ovf  (stack_ovf),
        .depth      (depth),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_clr  (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached stack: registered pop output, synchronous clear.
    logic [31:0] smem [8];
    logic [3:0]  sp = 4'd0;
    always @(posedge clk) begin
        if (stack_clr) begin
            sp <= 4'd0;
        end else if (stack_push) begin
            if (sp < 4'd8) begin
                smem[sp[2:0]] <= stack_din;
                sp <= sp + 4'd1;
            end
        end else if (stack_pop) begin
            if (sp > 4'd0) begin
                stack_dout <= smem[3'(sp - 4'd1)];
                sp <= sp - 4'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk1("ready_wait", req_ready, 1'b1);
    endtask

    task automatic check_init(input string tag);
        int n = 0;
        while (stack_clr !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk1({tag, "_clr_seen"}, stack_clr, 1'b1);
        chk1({tag, "_clr_busy"}, req_ready, 1'b0);
        step();
        chk1({tag, "_clr_once"}, stack_clr, 1'b0);
        chk1({tag, "_ready"}, req_ready, 1'b1);
        chk32({tag, "_depth"}, 32'(depth), 32'd0);
        chk1({tag, "_fault"}, fault, 1'b0);
    endtask

    // Holds in FAULT for a while, then clears it.
    task automatic clear_fault(input logic [1:0] code);
        repeat (2) begin
            step();
            chk1("flt_hold", fault, 1'b1);
            chk32("flt_code_hold", 32'(fault_code), 32'(code));
            chk1("flt_not_ready", req_ready, 1'b0);
            chk1("flt_no_push", stack_push, 1'b0);
            chk1("flt_no_pop", stack_pop, 1'b0);
            chk1("flt_no_load", pc_load, 1'b0);
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk1("clr_fault", fault, 1'b0);
        chk32("clr_code", 32'(fault_code), 32'd0);
        chk1("clr_ready", req_ready, 1'b1);
        chk32("clr_depth", 32'(depth), 32'(ras_q.size()));
    endtask

    task automatic do_call(input logic [31:0] pc_v, input logic [31:0] tgt_v);
        logic [31:0] ra;
        ra = pc_v + 32'd1;
        wait_ready();
        call_req = 1'b1;
        pc = pc_v;
        call_target = tgt_v;
        step();
        call_req = 1'b0;
        if (ras_q.size() == 8) begin
            chk1("ovf_fault", fault, 1'b1);
            chk32("ovf_code", 32'(fault_code), 32'd1);
            chk1("ovf_no_push", stack_push, 1'b0);
            chk32("ovf_depth", 32'(depth), 32'd8);
            cache_valid = 1'b0;
            clear_fault(2'd1);
        end else begin
            chk1("call_push", stack_push, 1'b1);
            chk1("call_no_pop", stack_pop, 1'b0);
            chk1("call_load", pc_load, 1'b1);
            chk32("call_pc_next", pc_next, tgt_v);
            chk32("call_din", stack_din, ra);
            ras_q.push_back(ra);
            cache_valid = 1'b1;
            step();
            chk1("call_load_drop", pc_load, 1'b0);
            chk1("call_ready", req_ready, 1'b1);
            chk32("call_depth", 32'(depth), 32'(ras_q.size()));
        end
    endtask

    task automatic do_ret();
        logic [31:0] exp_ra;
        wait_ready();
        ret_req = 1'b1;
        step();
        ret_req = 1'b0;
        if (ras_q.size() == 0) begin
            chk1("unf_fault", fault, 1'b1);
            chk32("unf_code", 32'(fault_code), 32'd2);
            chk1("unf_no_pop", stack_pop, 1'b0);
            chk32("unf_depth", 32'(depth), 32'd0);
            cache_valid = 1'b0;
            clear_fault(2'd2);
        end else begin
            exp_ra = ras_q.pop_back();
            chk1("ret_pop", stack_pop, 1'b1);
            chk1("ret_no_push", stack_push, 1'b0);
            if (CACHE_EN && cache_valid) begin
                chk1("ret_fast_load", pc_load, 1'b1);
                chk32("ret_fast_pc", pc_next, exp_ra);
                cache_valid = 1'b0;
                step();
            end else begin
                cache_valid = 1'b0;
                chk1("ret_pop_noload", pc_load, 1'b0);
                step();
                chk1("ret_wait_noload", pc_load, 1'b0);
                chk1("ret_wait_nopop", stack_pop, 1'b0);
                step();
                chk1("ret_load", pc_load, 1'b1);
                chk32("ret_pc_next", pc_next, exp_ra);
                step();
            end
            chk1("ret_load_drop", pc_load, 1'b0);
            chk1("ret_ready", req_ready, 1'b1);
            chk32("ret_depth", 32'(depth), 32'(ras_q.size()));
        end
    endtask

    initial begin
        reset = 1'b1;
        call_req = 1'b0;
        ret_req = 1'b0;
        pc = '0;
        call_target = '0;
        stack_ovf = 1'b0;
        fault_clr = 1'b0;
        cache_valid = 1'b0;

        // Reset values.
        repeat (3) step();
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_clr", stack_clr, 1'b0);
        chk1("rst_push", stack_push, 1'b0);
        chk1("rst_pop", stack_pop, 1'b0);
        chk1("rst_load", pc_load, 1'b0);
        chk32("rst_depth", 32'(depth), 32'd0);
        chk1("rst_fault", fault, 1'b0);
        chk32("rst_code", 32'(fault_code), 32'd0);
        chk32("rst_pc_next", pc_next, 32'd0);
        chk32("rst_din", stack_din, 32'd0);
        reset = 1'b0;
        check_init("por");

        // Basic CALL then RET.
        do_call(32'h100, 32'h200);
        do_ret();

        // Fill to the top, overflow, then unwind.
        for (int i = 0; i < 8; i++) do_call(32'(i), $urandom);
        do_call(32'h8, 32'h1234);
        for (int i = 0; i < 8; i++) do_ret();

        // Underflow at depth zero.
        do_ret();

        // Dual request.
        wait_ready();
        call_req = 1'b1;
        ret_req = 1'b1;
        step();
        call_req = 1'b0;
        ret_req = 1'b0;
        chk1("dual_fault", fault, 1'b1);
        chk32("dual_code", 32'(fault_code), 32'd3);
        chk1("dual_no_push", stack_push, 1'b0);
        chk1("dual_no_pop", stack_pop, 1'b0);
        chk1("dual_no_load", pc_load, 1'b0);
        clear_fault(2'd3);

        // Stack overflow flag seen while idle with one entry pushed.
        do_call(32'h40, 32'h80);
        wait_ready();
        stack_ovf = 1'b1;
        step();
        stack_ovf = 1'b0;
        cache_valid = 1'b0;
        chk1("sovf_fault", fault, 1'b1);
        chk32("sovf_code", 32'(fault_code), 32'd3);
        chk32("sovf_depth", 32'(depth), 32'd1);
        clear_fault(2'd3);
        do_ret();

        // fault_clr outside FAULT has no effect.
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk1("fclr_idle_ready", req_ready, 1'b1);
        chk1("fclr_idle_fault", fault, 1'b0);
        chk32("fclr_idle_depth", 32'(depth), 32'd0);

        // Return address wraps modulo 2^32.
        do_call(32'hFFFF_FFFF, 32'h44);
        do_ret();

        // Random CALL/RET walk.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) do_call($urandom, $urandom);
            else do_ret();
        end
        while (ras_q.size() > 0) do_ret();

        // Reset while a RET sits in WAIT.
        do_call(32'h300, 32'h500);
        do_call(32'h310, 32'h600);
        do_ret();
        wait_ready();
        ret_req = 1'b1;
        step();
        ret_req = 1'b0;
        chk1("mid_pop", stack_pop, 1'b1);
        step();
        chk1("mid_wait_noload", pc_load, 1'b0);
        reset = 1'b1;
        #1;
        chk1("mid_rst_pop", stack_pop, 1'b0);
        chk1("mid_rst_load", pc_load, 1'b0);
        chk1("mid_rst_ready", req_ready, 1'b0);
        chk32("mid_rst_depth", 32'(depth), 32'd0);
        ras_q.delete();
        cache_valid = 1'b0;
        step();
        chk1("mid_rst_hold_load", pc_load, 1'b0);
        reset = 1'b0;
        check_init("mid");
        do_call(32'h700, 32'h900);
        do_ret();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ras_sequencer.md
Name: ras_sequencer

Overview:
- Controller that sequences the 8-entry return-address stack for CALL/RET instructions issued by the control unit (UC).
- Accepts one request at a time over a valid/ready handshake and drives stack push/pop, including the return address to push.
- Loads the PC with the call target or popped return address.
- Keeps its own depth counter so overflow and underflow are caught before the stack is touched; latches faults until cleared.

Parameters:
- DEPTH, 8, stack entries; must match the stack instance.
- PC_W, 32, PC / return-address width.
- RET_OFFSET, 1, added to pc to form the pushed return address (word-addressed PC).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  1  UC requests CALL.
- ret_req  in  1  UC requests RET.
- req_ready  out  1  sequencer can accept a request this cycle.
- pc  in  PC_W  PC of the CALL instruction.
- call_target  in  PC_W  jump target of the CALL.
- pc_load  out  1  one-cycle strobe: PC must load pc_next.
- pc_next  out  PC_W  new PC value, valid when pc_load=1.
- stack_clr  out  1  synchronous clear to the stack's reset input.
- stack_push  out  1  to the stack's writeStack input.
- stack_pop  out  1  to the stack's readStack input.
- stack_din  out  PC_W  to the stack's pc input.
- stack_dout  in  PC_W  from the stack's stackOut output.
- stack_ovf  in  1  from the stack's stackOverflow output.
- depth  out  4  current number of valid entries, 0..DEPTH.
- fault  out  1  sticky fault flag.
- fault_code  out  2  fault cause: 0 none, 1 overflow, 2 underflow, 3 illegal (dual request or stack_ovf).
- fault_clr  in  1  clears the fault and returns the sequencer to IDLE.

Behaviour:
- All outputs are registered. Reset values: state INIT, depth=0, fault=0, fault_code=0, pc_next=0, stack_din=0, all strobes 0, req_ready=0.
- States and transitions:
  - INIT (1 cycle after reset release): stack_clr=1 -> IDLE.
  - IDLE: req_ready=1. A request is accepted on a rising edge with (call_req|ret_req)=1.
  - Both call_req and ret_req high -> FAULT, code 3; no stack operation.
  - CALL with depth==DEPTH -> FAULT, code 1; no push.
  - CALL with depth<DEPTH -> PUSH. Latch stack_din=pc+RET_OFFSET (mod 2^PC_W) and pc_next=call_target.
  - RET with depth==0 -> FAULT, code 2; no pop.
  - RET with depth>0 -> POP.
  - PUSH (1 cycle): stack_push=1, pc_load=1; depth+1 at the closing edge -> IDLE.
  - POP (1 cycle): stack_pop=1 -> WAIT.
  - WAIT (1 cycle): stack_dout is now valid; capture it into pc_next -> LOAD.
  - LOAD (1 cycle): pc_load=1; depth-1 at the closing edge -> IDLE.
  - FAULT: req_ready=0, fault=1, fault_code held. fault_clr=1 -> IDLE (fault and code cleared). depth is unchanged by any fault.
- Latency, counted from the acceptance edge:
  - CALL: pc_load in the next cycle; throughput 1 CALL per 2 cycles.
  - RET: pc_load 3 cycles after acceptance.
- req_ready=0 in every state except IDLE. Requests asserted while not ready are ignored; the UC must hold them.
- stack_ovf=1 sampled in any state other than INIT/FAULT -> FAULT, code 3. This is a depth-mirror mismatch.
- stack_push and stack_pop are never asserted in the same cycle.
- reset asserted mid-operation: immediate return to reset values; any in-flight push/pop strobe drops at once; the INIT clear follows.
- fault_clr outside FAULT: no effect.

Optional Feature:
- RAS_TOP_CACHE_EN defined:
  - Add a top-of-stack register plus a valid bit. Each push loads it with stack_din and sets valid.
  - A RET accepted while valid=1 still issues the pop, but asserts pc_load in the POP cycle with pc_next=cached value, then returns to IDLE. RET latency becomes 1 cycle.
  - valid clears on any pop, fault, or reset.
- Undefined: no cache; RET always goes through WAIT/LOAD.

Test Plan:
- Reset then idle: reset pulse -> stack_clr=1 for exactly 1 cycle, then req_ready=1, depth=0, fault=0.
- CALL then RET: pc=0x100, call_target=0x200, CALL -> PUSH cycle shows stack_din=0x101 and pc_load with pc_next=0x200, depth=1. RET -> pc_load with pc_next=0x101 three cycles after acceptance (one cycle with RAS_TOP_CACHE_EN), depth=0.
- Overflow: 8 CALLs with pc=0..7, then a 9th CALL -> fault=1, fault_code=1, no stack_push, depth=8. Then fault_clr, then 8 RETs -> pc_next sequence 8,7,...,1.
- Underflow: RET at depth=0 -> fault=1, fault_code=2, stack_pop never asserted, req_ready=0 until fault_clr.
- Dual request: call_req=ret_req=1 in IDLE -> fault_code=3, no strobes. Separately, force stack_ovf=1 in IDLE -> fault_code=3.
- Reset during RET in WAIT -> stack_pop and pc_load stay 0, depth=0, INIT clear cycle follows.
